// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller / execution interface:
// operation encoding, execution FSM states and small decode helpers.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_GE    = 4'b1001,
        OP_NE    = 4'b1010,
        OP_RSV_B = 4'b1011,
        OP_LT    = 4'b1100,
        OP_RSV_D = 4'b1101,
        OP_RSV_E = 4'b1110,
        OP_ONE   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU operations: logic, add/sub, compares and constant codes.
// Shift and reserved codes return zero; shifts are handled by the sequencer.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-2:0] zext_s;

    assign zext_s = '0;

    // Operation select; compare results are zero-extended single bits.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = src_a & src_b;
            OP_OR:   result = src_a | src_b;
            OP_ADD:  result = src_a + src_b;
            OP_XOR:  result = src_a ^ src_b;
            OP_SUB:  result = src_a - src_b;
            OP_EQ:   result = {zext_s, (src_a == src_b)};
            OP_GE:   result = {zext_s, ($signed(src_a) >= $signed(src_b))};
            OP_NE:   result = {zext_s, (src_a != src_b)};
            OP_LT:   result = {zext_s, ($signed(src_a) < $signed(src_b))};
            OP_ONE:  result = {zext_s, 1'b1};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Handshaked ALU execution stage: single-cycle ops complete in one cycle,
// shifts iterate one bit per cycle; result is held until the consumer accepts.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] Operation,
    input  logic [WIDTH-1:0]    SrcA,
    input  logic [WIDTH-1:0]    SrcB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    ALUResult,
    output logic                Zero,
    output logic                Busy
);

    alu_state_e       state_r, state_s;
    alu_op_e          op_r, op_s, op_in_s;
    logic [WIDTH-1:0] shreg_r, shreg_s, shift_one_s;
    logic [SHW-1:0]   cnt_r, cnt_s, amt_s;
    logic [WIDTH-1:0] result_r, result_s, comb_res_s;
    logic             zero_r, zero_s;

    assign op_in_s = alu_op_e'(Operation);
    assign amt_s   = SrcB[SHW-1:0];

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .op     (op_in_s),
        .src_a  (SrcA),
        .src_b  (SrcB),
        .result (comb_res_s)
    );

    // One-bit step of the shift register in the latched op's direction.
    always_comb begin
        shift_one_s = shreg_r;
        case (op_r)
            OP_SLL:  shift_one_s = {shreg_r[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_one_s = {1'b0, shreg_r[WIDTH-1:1]};
            OP_SRA:  shift_one_s = {shreg_r[WIDTH-1], shreg_r[WIDTH-1:1]};
            default: shift_one_s = shreg_r;
        endcase
    end

    // Next-state and datapath-load decisions for the execution FSM.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_s = op_in_s;
                    if (!is_shift_op(op_in_s)) begin
                        result_s = comb_res_s;
                        state_s  = ST_DONE;
                    end else if (amt_s == '0) begin
                        result_s = SrcA;
                        state_s  = ST_DONE;
                    end else begin
                        shreg_s = SrcA;
                        cnt_s   = amt_s;
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_s = shift_one_s;
                cnt_s   = cnt_r - SHW'(1);
                // The step taken with count 1 is the final one.
                if (cnt_r == SHW'(1)) begin
                    result_s = shift_one_s;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        zero_s = (result_s == '0);
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_AND;
            shreg_r  <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            zero_r   <= 1'b1;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            zero_r   <= zero_s;
        end
    end

    assign ALUResult = result_r;
    assign Zero      = zero_r;
    assign out_valid = (state_r == ST_DONE);
    assign in_ready  = (state_r == ST_IDLE);
    assign Busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed bench for alu_seq_exec against an arithmetic
// reference model of the operation set and its latency.
module tb_alu_seq_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int amt;
        amt = int'(b[4:0]);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h4:    return a << amt;
            4'h5:    return a >> amt;
            4'h6:    return a - b;
            4'h7:    return 32'($signed(a) >>> amt);
            4'h8:    return (a == b) ? 32'd1 : 32'd0;
            4'h9:    return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'hA:    return (a != b) ? 32'd1 : 32'd0;
            4'hC:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hF:    return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'h4 || op == 4'h5 || op == 4'h7) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        else
            return 1;
    endfunction

    // Issue one request, check latency/result, stall the consumer, then release.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp;
        int lat;
        int cyc;
        exp = model(op, a, b);
        lat = latency(op, b);
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(lat));
        check_eq({tag, "_result"}, ALUResult, exp);
        check_eq({tag, "_zero"}, {31'd0, Zero}, (exp == 32'd0) ? 32'd1 : 32'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
            @(posedge clk); #1;
            check_eq({tag, "_hold_result"}, ALUResult, exp);
            check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] ra, rb, ev;
        logic [3:0]  rop;
        int nacc, nres, cyc, last_acc;
        logic will_acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
        #12;
        check_eq("rst_result", ALUResult, 32'd0);
        check_eq("rst_zero", {31'd0, Zero}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap", 4'h2, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sub_neg", 4'h6, 32'd5, 32'd7, 1);
        run_op("sra_31", 4'h7, 32'h8000_0000, 32'd31, 0);
        run_op("srl_amt0", 4'h5, 32'hDEAD_BEEF, 32'h0000_0100, 0);
        run_op("sll_4", 4'h4, 32'h1234_5678, 32'hFFFF_FFE4, 0);
        run_op("lt_neg", 4'hC, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("ge_neg", 4'h9, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("eq_77", 4'h8, 32'd7, 32'd7, 0);
        run_op("ne_77", 4'hA, 32'd7, 32'd7, 0);
        run_op("one", 4'hF, 32'd0, 32'd0, 0);
        run_op("rsv_e", 4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("xor_bp", 4'h3, 32'hF0F0_F0F0, 32'hFFFF_0000, 5);

        // Reset in the middle of a long shift must discard it.
        Operation = 4'h4; SrcA = 32'h0000_0001; SrcB = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_result", ALUResult, 32'd0);
        check_eq("midrst_zero", {31'd0, Zero}, 32'd1);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        check_eq("midrst_no_stale", 32'(cyc), 32'd0);
        out_ready = 1'b0;

        // Back-to-back requests with in_valid held high.
        nacc = 0; nres = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        ra = $urandom; rb = $urandom;
        Operation = 4'h2; SrcA = ra; SrcB = rb; in_valid = 1'b1;
        while (nres < 4 && cyc < 40) begin
            will_acc = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("b2b_extra_result", ALUResult, 32'hxxxx_xxxx);
                end else begin
                    ev = exp_q.pop_front();
                    check_eq("b2b_result", ALUResult, ev);
                end
                nres++;
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(model(4'h2, SrcA, SrcB));
                if (last_acc >= 0) check_eq("b2b_gap", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                nacc++;
                will_acc = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (will_acc) begin
                if (nacc < 4) begin
                    SrcA = $urandom; SrcB = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check_eq("b2b_accepts", 32'(nacc), 32'd4);
        check_eq("b2b_results", 32'(nres), 32'd4);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized operations over the full opcode space.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 0) rb = ra;
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution end of the 4-bit Operation interface driven by the ALU controller.
- Takes a handshaked operation request (Operation, SrcA, SrcB) and produces a registered result.
- Result is a data value for arithmetic, logic and shift codes, or a 0/1 condition for compare, branch and jump codes.
- Shifts run iteratively, one bit per cycle, so no barrel shifter is needed. Sits between the ID/EX operand registers and the EX/MEM latch in the multi-cycle datapath.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived, do not override)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
Operation  input  4  operation code, encoding under Behaviour
SrcA  input  WIDTH  operand A
SrcB  input  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ALUResult  output  WIDTH  result
Zero  output  1  ALUResult == 0
Busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ALUResult=0, Zero=1, out_valid=0, in_ready=1, Busy=0.
  - Internal shift counter and operand registers are cleared.
  - Reset mid-shift or mid-DONE discards the operation; no result is emitted.
- Operation encoding (fixed):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 EQ (BEQ), 1001 GE signed (BGE), 1010 NE (BNE), 1100 LT signed (BLT/SLT).
  - 1111 ONE (JAL, result=1).
  - Codes 1011, 1101, 1110 are reserved; they produce result 0 with single-cycle latency.
- Arithmetic and width:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - Compare codes return 32'h1 or 32'h0, zero-extended to WIDTH.
  - SRA replicates SrcA[WIDTH-1].
  - Shift amount = SrcB[SHW-1:0]; upper bits of SrcB are ignored for shifts.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. A transfer occurs when in_valid && in_ready.
    - Non-shift op: compute combinationally, register into ALUResult, go to DONE.
    - Shift op with amount 0: ALUResult <= SrcA, go to DONE.
    - Shift op with amount N>0: load SrcA into the shift register and N into the counter, go to SHIFT.
  - SHIFT: each cycle shift by 1 in the op's direction and decrement the counter. When the counter reaches 1, that cycle's shift is the last; register the result and go to DONE. in_ready=0.
  - DONE: out_valid=1. ALUResult and Zero are stable while out_valid && !out_ready. On out_ready, go to IDLE and drop out_valid next cycle.
- Latency (request accepted in cycle 0):
  - Non-shift and zero-amount shift: out_valid in cycle 1.
  - Shift by N: out_valid in cycle N+1.
  - Maximum is WIDTH cycles (N=WIDTH-1).
- Throughput: at most one request per 2 cycles. in_ready is low in DONE even if out_ready is high; no accept/complete overlap.
- Inputs are sampled only on the accept edge. Changes to Operation/SrcA/SrcB after accept have no effect.
- in_valid while in_ready=0 is ignored, not queued. The requester must hold the request until the transfer.
- Zero is registered together with ALUResult.
- Busy=1 in SHIFT and DONE.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the encoding above (OP_AND..OP_ONE), shared with the ALU controller.
  - typedef enum logic [1:0] for the FSM states.
  - Constant ALU_OP_W=4.
- One sub-module, alu_comb_unit: purely combinational single-cycle ops (logic, add/sub, compares, ONE, reserved->0). It is reusable by a future single-cycle datapath.
- FSM, shift register and counter stay in alu_seq_exec.

Test Plan:
- Reset: drive rst_n=0 mid-SHIFT (SLL by 20) -> out_valid=0, ALUResult=0, Zero=1, in_ready=1 immediately. No stale result after rst_n=1.
- ADD then SUB: op 0010, A=32'hFFFF_FFFF, B=1 -> cycle 1 ALUResult=0, Zero=1. Then op 0110, A=5, B=7 -> 32'hFFFF_FFFE, Zero=0.
- Shifts:
  - SRA: op 0111, A=32'h8000_0000, B=31 -> ALUResult=32'hFFFF_FFFF, out_valid exactly in cycle 32.
  - SRL: op 0101, B=32'h0000_0100 (amount 0) -> ALUResult=A in cycle 1.
- Compares:
  - op 1100, A=32'hFFFF_FFFF (-1), B=0 -> 1.
  - op 1001, same operands -> 0.
  - op 1000, A=B=7 -> 1.
  - op 1010, A=B=7 -> 0.
  - op 1111 -> 1.
  - op 1110 -> 0.
- Backpressure: out_ready=0 for 5 cycles after XOR A=32'hF0F0_F0F0, B=32'hFFFF_0000 -> ALUResult=32'h0F0F_F0F0 held stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid held high with 4 ADD requests and out_ready=1 -> an accept every 2 cycles, results in order, none lost or duplicated.
